// File: rtl/mux_scan_pkg.sv
// Shared types and sizing for the mux scan controller.
// Holds the FSM state encoding, the channel count and the settle counter width.
package mux_scan_pkg;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef logic [CNT_W-1:0]  cnt_t;
    typedef logic [CH_W-1:0]   chan_t;
    typedef logic [NUM_CH-1:0] mask_t;
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// Bundle of the scan request, the mux/demux drive lines and the scan results.
// master = scan controller, slave = requester plus the mux/demux stage.
interface mux_scan_ctrl_if;
    import mux_scan_pkg::*;

    logic  start;
    mask_t chan_mask;
    logic  ym;
    chan_t sel;
    logic  mux_en;
    logic  demux_en;
    logic  idm;
    logic  busy;
    logic  done;
    mask_t sample;

    modport master (
        input  start, chan_mask, ym,
        output sel, mux_en, demux_en, idm, busy, done, sample
    );

    modport slave (
        output start, chan_mask, ym,
        input  sel, mux_en, demux_en, idm, busy, done, sample
    );
endinterface

// File: rtl/mux_scan_ctrl_chan_pick.sv
// Picks the lowest set mask bit (first=1) or the lowest set bit above cur (first=0).
// Latency: purely combinational. Backpressure: none, valid=0 when nothing qualifies.
module chan_pick
    import mux_scan_pkg::*;
(
    input  mask_t mask,
    input  chan_t cur,
    input  logic  first,
    output chan_t nxt,
    output logic  valid
);
    always_comb begin
        nxt   = '0;
        valid = 1'b0;
        // Descending walk so the last hit, i.e. the lowest qualifying index, wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (first || (i > int'(cur)))) begin
                nxt   = CH_W'(i);
                valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the masked channels of a 4:1 mux, captures ym per channel and replays it to the demux.
// Latency: done in cycle 1+N*(SETTLE_CYC+1) after start is accepted. Backpressure: start ignored while busy.
module mux_scan_ctrl
    import mux_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_scan_ctrl_if.master  bus
);
    state_t state;
    chan_t  sel_q;
    cnt_t   cnt;
    mask_t  mask_q;
    mask_t  sample_q;

    chan_t  first_nxt;
    logic   first_vld;
    chan_t  next_nxt;
    logic   next_vld;

    // First channel comes from the live mask so it can be loaded on the accepting edge.
    chan_pick u_pick_first (
        .mask  (bus.chan_mask),
        .cur   ('0),
        .first (1'b1),
        .nxt   (first_nxt),
        .valid (first_vld)
    );

    chan_pick u_pick_next (
        .mask  (mask_q),
        .cur   (sel_q),
        .first (1'b0),
        .nxt   (next_nxt),
        .valid (next_vld)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel_q    <= '0;
            cnt      <= '0;
            mask_q   <= '0;
            sample_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask_q   <= bus.chan_mask;
                        sample_q <= '0;
                        cnt      <= '0;
                        if (first_vld) begin
                            sel_q <= first_nxt;
                            state <= SETTLE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == cnt_t'(SETTLE_CYC - 1)) begin
                        cnt             <= '0;
                        sample_q[sel_q] <= bus.ym;
                        state           <= WRITE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    if (next_vld) begin
                        sel_q <= next_nxt;
                        state <= SETTLE;
                    end else begin
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode from registers only; ym reaches nothing but sample_q.
    assign bus.sel      = sel_q;
    assign bus.mux_en   = (state == SETTLE);
    assign bus.demux_en = (state == WRITE);
    assign bus.idm      = (state == WRITE) & sample_q[sel_q];
    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.sample   = sample_q;
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 2: cycles the mux select is held stable before Ym is captured; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  scan request; sampled only in IDLE.
REQ-005 chan_mask  input  4  channels to scan, bit i = channel i; latched on accepted start.
REQ-006 ym  input  1  mux output returned from the 4:1 mux stage.
REQ-007 sel  output  2  select lines driving mux S and demux S.
REQ-008 mux_en  output  1  mux enable (active-high).
REQ-009 demux_en  output  1  demux enable (active-high).
REQ-010 idm  output  1  demux data input; carries the bit just captured.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle completion pulse.
REQ-013 sample  output  4  captured ym values, bit i = channel i.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, WRITE, DONE.
REQ-015 IDLE with start=1: latch chan_mask, clear sample to 4'b0000, load the lowest set mask bit into sel, enter SETTLE; mask 4'b0000 enters DONE directly.
REQ-016 SETTLE: mux_en=1, demux_en=0, sel constant; a 4-bit counter runs SETTLE_CYC cycles; on the edge ending the last cycle, sample[sel] <= ym and the FSM enters WRITE.
REQ-017 WRITE lasts exactly 1 cycle: mux_en=0, demux_en=1, idm=sample[sel], sel unchanged.
REQ-018 Leaving WRITE: if a higher set mask bit remains, sel <= the next higher set bit and the FSM enters SETTLE; otherwise it enters DONE.
REQ-019 DONE lasts 1 cycle with done=1, then the FSM returns to IDLE; sample holds until the next accepted start.
REQ-020 Latency: with N set mask bits, done SHALL be high in cycle 1+N*(SETTLE_CYC+1) after the edge that accepts start, N=0 giving cycle 1.
REQ-021 start while busy=1 SHALL be ignored, with no queuing; start held high through DONE is accepted again in the following IDLE cycle.
REQ-022 Channels are visited in ascending index order; unmasked sample bits remain 0.
REQ-023 mux_en and demux_en SHALL never be high in the same cycle; idm=0 outside WRITE.
REQ-024 chan_mask changes after acceptance SHALL have no effect on the running scan.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, with sel=0, mux_en=0, demux_en=0, idm=0, busy=0, done=0, sample=0, counter=0 and latched mask=0.
REQ-026 Reset during any state SHALL abort the scan without emitting done; operation resumes at the first rising edge after rst_n goes high.

Structure
REQ-027 State encodings, channel count (4) and counter width (4) SHALL reside in shared package mux_scan_pkg.
REQ-028 Next-channel selection SHALL be a combinational sub-module chan_pick, with inputs mask[3:0] and cur[1:0] and a first-flag, and outputs nxt[1:0] and valid.
REQ-029 All outputs SHALL be driven directly from registers or from state decode, with no combinational path from ym to any output.

Verification
REQ-030 SETTLE_CYC=2, mask=4'b1111, ym=1 on channels 0 and 2 -> sel 0,1,2,3; sample=4'b0101; done in cycle 13.
REQ-031 mask=4'b1010, ym tied 1 -> only sel=1 and sel=3 are visited; idm=1 in both WRITE cycles; sample=4'b1010; done in cycle 7.
REQ-032 mask=4'b0000 -> busy high for 1 cycle, done in cycle 1, sample=0, and mux_en and demux_en never assert.
REQ-033 start pulsed again in cycle 4 of a scan -> ignored; exactly one done pulse; the sequence is identical to the single-start run.
REQ-034 rst_n low in cycle 5 of a 4-channel scan -> all outputs 0 asynchronously; no done; a new start after release runs a full scan.
REQ-035 Whole-run assertion: mux_en and demux_en are never both 1, and sel is stable throughout every SETTLE period.
